// File: rtl/sprite_compositor.sv
// Sprite compositor: layers prioritised rectangular sprites over a tile/background colour and
// records per-frame overlaps between sprite 0 and the other sprites for hit detection.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 6,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SIZE_W      = 6,
  parameter int unsigned RGB_W       = 12,
  parameter int unsigned BLINK_LOG2  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frameStart,
  input  logic                            bright,
  input  logic [COORD_W-1:0]              hCount,
  input  logic [COORD_W-1:0]              vCount,
  input  logic [NUM_SPRITES*2*COORD_W-1:0] spritePos,
  input  logic [NUM_SPRITES*2*SIZE_W-1:0]  spriteSize,
  input  logic [NUM_SPRITES*RGB_W-1:0]     spriteColor,
  input  logic [NUM_SPRITES-1:0]           spriteEnable,
  input  logic [NUM_SPRITES-1:0]           spriteBlink,
  input  logic                             tileZone,
  input  logic [RGB_W-1:0]                 tileRgb,
  input  logic [RGB_W-1:0]                 bgRgb,
  output logic [RGB_W-1:0]                 rgb,
  output logic [NUM_SPRITES-1:0]           overlapMask,
  output logic [15:0]                      frameCount
);

  logic [NUM_SPRITES*2*COORD_W-1:0] pos_q;
  logic [NUM_SPRITES*2*SIZE_W-1:0]  size_q;
  logic [NUM_SPRITES*RGB_W-1:0]     color_q;
  logic [NUM_SPRITES-1:0]           en_q;
  logic [NUM_SPRITES-1:0]           blink_q;
  logic [NUM_SPRITES-1:0]           acc_q;
  logic [NUM_SPRITES-1:0]           mask_q;
  logic [15:0]                      fc_q;
  logic [RGB_W-1:0]                 rgb_q;

  logic [NUM_SPRITES-1:0] hit;
  logic [NUM_SPRITES-1:0] ov;
  logic [RGB_W-1:0]       pix_color;

  // Extents are formed one bit wider so sprites near the right/bottom edge never wrap to 0.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [COORD_W-1:0] x, y;
    logic [SIZE_W-1:0]  w, h;
    logic [COORD_W:0]   x_end, y_end;
    logic               visible;

    assign x       = pos_q[i*2*COORD_W+COORD_W +: COORD_W];
    assign y       = pos_q[i*2*COORD_W +: COORD_W];
    assign w       = size_q[i*2*SIZE_W+SIZE_W +: SIZE_W];
    assign h       = size_q[i*2*SIZE_W +: SIZE_W];
    assign x_end   = {1'b0, x} + (COORD_W+1)'(w);
    assign y_end   = {1'b0, y} + (COORD_W+1)'(h);
    assign visible = ~blink_q[i] | ~fc_q[BLINK_LOG2-1];
    assign hit[i]  = en_q[i] & visible & (hCount >= x) & ({1'b0, hCount} < x_end)
                   & (vCount >= y) & ({1'b0, vCount} < y_end);
  end

  always_comb begin
    pix_color = tileZone ? tileRgb : bgRgb;
    // Walk from lowest to highest priority so sprite 0 overwrites last.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = color_q[i*RGB_W +: RGB_W];
    end
    ov    = hit & {NUM_SPRITES{hit[0] & bright}};
    ov[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      size_q  <= '0;
      color_q <= '0;
      en_q    <= '0;
      blink_q <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      fc_q    <= '0;
      rgb_q   <= '0;
    end else begin
      rgb_q <= bright ? pix_color : '0;
      if (frameStart) begin
        pos_q   <= spritePos;
        size_q  <= spriteSize;
        color_q <= spriteColor;
        en_q    <= spriteEnable;
        blink_q <= spriteBlink;
        fc_q    <= fc_q + 16'd1;
        mask_q  <= acc_q | ov;
        acc_q   <= '0;
      end else begin
        acc_q <= acc_q | ov;
      end
    end
  end

  assign rgb         = rgb_q;
  assign overlapMask = mask_q;
  assign frameCount  = fc_q;

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the fixed-object display controller.
- Composites NUM_SPRITES rectangular sprites over a tile-layer colour for the VGA pixel stream.
- Per-sprite parameters are snapshotted at frameStart. Each sprite has its own size, colour, enable and blink.
- Produces a registered RGB output and a per-frame sticky overlap mask between sprite 0 (player) and every other sprite, used by game logic for hit detection.

Parameters:
- NUM_SPRITES, 6, number of sprite channels; index 0 has highest priority.
- COORD_W, 10, width of hCount/vCount and sprite coordinates.
- SIZE_W, 6, width of per-sprite width/height fields (0..63 pixels).
- RGB_W, 12, colour width.
- BLINK_LOG2, 3, blink period is 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frameStart  in  1  one-cycle pulse at the start of each frame.
- bright  in  1  visible-area flag.
- hCount  in  COORD_W  current pixel x.
- vCount  in  COORD_W  current pixel y.
- spritePos  in  NUM_SPRITES*2*COORD_W  per sprite {x,y}; sprite i occupies bits [i*2*COORD_W +: 2*COORD_W]; x is the upper half; top-left anchor.
- spriteSize  in  NUM_SPRITES*2*SIZE_W  per sprite {w,h}; same packing as spritePos.
- spriteColor  in  NUM_SPRITES*RGB_W  per-sprite colour.
- spriteEnable  in  NUM_SPRITES  sprite drawn when 1.
- spriteBlink  in  NUM_SPRITES  sprite blinks when 1.
- tileZone  in  1  tile layer covers the current pixel.
- tileRgb  in  RGB_W  tile-layer colour.
- bgRgb  in  RGB_W  background colour.
- rgb  out  RGB_W  registered pixel colour.
- overlapMask  out  NUM_SPRITES  previous frame's sprite-0 overlap flags; bit 0 is always 0.
- frameCount  out  16  frames since reset; wraps.

Behaviour:
- Reset, asynchronous:
  - Outputs: rgb=0, overlapMask=0, frameCount=0.
  - Internal: all shadow registers (pos/size/colour/enable/blink) = 0; overlap accumulator = 0.
- Snapshot: on a clk edge with frameStart=1:
  - Shadow registers load from the inputs.
  - frameCount increments, wrapping from 0xFFFF to 0.
  - overlapMask <= accumulator OR any overlap detected in this same cycle.
  - Accumulator clears to 0.
  - Input changes mid-frame have no effect until the next frameStart.
- Hit test, per sprite, combinational on the shadow values:
  - hit_i = en_i & visible_i & (hCount >= x_i) & (hCount < x_i + w_i) & (vCount >= y_i) & (vCount < y_i + h_i).
  - Sums are computed at COORD_W+1 bits, so sprites near the coordinate limit never wrap.
  - w=0 or h=0 means no hit.
- Blink: visible_i = ~blink_i | ~frameCount[BLINK_LOG2-1].
  - BLINK_LOG2=3: frames 0-3 shown, frames 4-7 hidden, repeating.
- Priority:
  - bright=0 -> black (0).
  - Otherwise, lowest-index hit sprite colour, else tileRgb if tileZone, else bgRgb.
- Latency: rgb is registered, so the colour for pixel (hCount, vCount) appears exactly 1 clk later. The same applies to bright.
- Overlap accumulation:
  - Each cycle with bright=1: acc[i] |= hit_0 & hit_i for i>=1.
  - Pixels with bright=0 never set bits.
  - acc[0] is held at 0.
- Simultaneous events: frameStart in the same cycle as an overlap pixel -> that overlap is included in the published overlapMask, and the accumulator still clears.
- Reset asserted mid-frame: all state clears immediately. Sprites stay undrawn until the first frameStart after release.

Test Plan:
- Reset then frameStart with sprite0 {x=100,y=50,w=32,h=32,color=F00,en=1}, bright=1 -> rgb=F00 at pixels (100,50) and (131,81) one clk later; bgRgb at (132,50) and (99,50).
- Sprites 0 and 2 both cover (200,200), colours F00 and 0F0 -> rgb=F00; disable sprite 0 and pulse frameStart -> 0F0. Change spriteColor without frameStart -> output unchanged.
- Sprite 0 at (10,10) 16x16 and sprite 3 at (20,20) 16x16, full frame scan -> after next frameStart overlapMask=6'b001000. A following frame with no overlap -> overlapMask=0.
- Sprite 1 blink=1 -> hidden on frames with frameCount=4..7, shown on 0..3; overlap bits for sprite 1 stay 0 while hidden.
- Sprite at x=1020, w=10 -> no pixels drawn at hCount 0..5 (no wrap); w=0 -> never drawn.
- bright=0 over a sprite -> rgb=0 and no overlap recorded. Assert rst_n=0 mid-frame -> rgb, overlapMask and frameCount=0 immediately.
